// File: rtl/wb_align.sv
// wb_align: lockstep write-back aligner for the dual-core comparator.
// Each core's register-file write-backs are buffered in a small FIFO. They are
// released strictly as matched pairs (N-th write of A with N-th write of B).
// Excessive one-sided skew and FIFO overflow are reported as sticky errors.
// Optional feature: define WB_ALIGN_STATS_EN to add a 32-bit emitted-pair counter
// (pair_cnt_o). rst_i clears the counter; flush_i does not.
//
// state  | meaning
// IDLE   | both FIFOs empty, or both non-empty
// SKEW_A | only core A has buffered writes
// SKEW_B | only core B has buffered writes
// ERR    | skew limit reached; frozen until flush_i or rst_i
module wb_align #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int SKEW_MAX   = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  we_a_i,
  input  logic [ADDR_WIDTH-1:0] addr_a_i,
  input  logic [DATA_WIDTH-1:0] data_a_i,
  input  logic                  we_b_i,
  input  logic [ADDR_WIDTH-1:0] addr_b_i,
  input  logic [DATA_WIDTH-1:0] data_b_i,
  output logic                  we_a_o,
  output logic                  we_b_o,
  output logic [ADDR_WIDTH-1:0] addr_a_o,
  output logic [ADDR_WIDTH-1:0] addr_b_o,
  output logic [DATA_WIDTH-1:0] data_a_o,
  output logic [DATA_WIDTH-1:0] data_b_o,
  output logic                  full_a_o,
  output logic                  full_b_o,
  output logic                  skew_err_o,
  output logic                  ovf_err_o
`ifdef WB_ALIGN_STATS_EN
  ,
  output logic [31:0]           pair_cnt_o
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(SKEW_MAX + 1);
  localparam int EW = ADDR_WIDTH + DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, SKEW_A, SKEW_B, ERR} state_e;

  state_e          state_q, state_d, side;
  logic [EW-1:0]   mem_a_q [DEPTH];
  logic [EW-1:0]   mem_b_q [DEPTH];
  logic [PW-1:0]   wr_a_q, rd_a_q, wr_b_q, rd_b_q;
  logic [CW-1:0]   cnt_a_q, cnt_b_q, cnt_a_d, cnt_b_d;
  logic [SW-1:0]   skew_q, skew_d, skew_inc;
  logic            full_a, full_b, pop, push_a, push_b, ovf_set, skew_set;
  logic            we_q, skew_err_q, ovf_err_q;
  logic [EW-1:0]   head_a, head_b;
  logic [EW-1:0]   out_a_q, out_b_q;

  // Pop/push decisions, post-edge counts and next FSM state.
  always_comb begin
    full_a   = (cnt_a_q == CW'(DEPTH));
    full_b   = (cnt_b_q == CW'(DEPTH));
    pop      = (state_q != ERR) && (cnt_a_q != '0) && (cnt_b_q != '0);
    // A full FIFO still accepts a push when its head leaves at the same edge.
    push_a   = we_a_i && (state_q != ERR) && (!full_a || pop);
    push_b   = we_b_i && (state_q != ERR) && (!full_b || pop);
    ovf_set  = (state_q != ERR) &&
               ((we_a_i && full_a && !pop) || (we_b_i && full_b && !pop));
    cnt_a_d  = cnt_a_q + CW'(push_a) - CW'(pop);
    cnt_b_d  = cnt_b_q + CW'(push_b) - CW'(pop);
    head_a   = mem_a_q[rd_a_q];
    head_b   = mem_b_q[rd_b_q];
    skew_inc = skew_q + SW'(1);
    state_d  = state_q;
    skew_d   = skew_q;
    skew_set = 1'b0;
    side     = IDLE;
    if (cnt_a_d != '0 && cnt_b_d == '0) begin
      side = SKEW_A;
    end else if (cnt_b_d != '0 && cnt_a_d == '0) begin
      side = SKEW_B;
    end
    if (state_q != ERR) begin
      if (side == IDLE || state_q == IDLE) begin
        // Entering or leaving a skew episode restarts the timer.
        state_d = side;
        skew_d  = '0;
      end else if (skew_inc == SW'(SKEW_MAX)) begin
        state_d  = ERR;
        skew_d   = skew_inc;
        skew_set = 1'b1;
      end else begin
        state_d = side;
        skew_d  = skew_inc;
      end
    end
  end

  // FIFO storage; stale slots are harmless because pointers are reset instead.
  always_ff @(posedge clk_i) begin
    if (push_a) mem_a_q[wr_a_q] <= {addr_a_i, data_a_i};
    if (push_b) mem_b_q[wr_b_q] <= {addr_b_i, data_b_i};
  end

  // Control state, pointers, counts, sticky errors and registered pair outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      skew_q     <= '0;
      wr_a_q     <= '0;
      rd_a_q     <= '0;
      wr_b_q     <= '0;
      rd_b_q     <= '0;
      cnt_a_q    <= '0;
      cnt_b_q    <= '0;
      we_q       <= 1'b0;
      out_a_q    <= '0;
      out_b_q    <= '0;
      skew_err_q <= 1'b0;
      ovf_err_q  <= 1'b0;
    end else if (flush_i) begin
      state_q    <= IDLE;
      skew_q     <= '0;
      wr_a_q     <= '0;
      rd_a_q     <= '0;
      wr_b_q     <= '0;
      rd_b_q     <= '0;
      cnt_a_q    <= '0;
      cnt_b_q    <= '0;
      we_q       <= 1'b0;
      skew_err_q <= 1'b0;
      ovf_err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      skew_q  <= skew_d;
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
      we_q    <= pop;
      if (push_a) wr_a_q <= wr_a_q + PW'(1);
      if (push_b) wr_b_q <= wr_b_q + PW'(1);
      if (pop) begin
        rd_a_q  <= rd_a_q + PW'(1);
        rd_b_q  <= rd_b_q + PW'(1);
        out_a_q <= head_a;
        out_b_q <= head_b;
      end
      if (skew_set) skew_err_q <= 1'b1;
      if (ovf_set)  ovf_err_q  <= 1'b1;
    end
  end

`ifdef WB_ALIGN_STATS_EN
  logic [31:0] pair_cnt_q;

  // Emitted-pair statistics survive flush so halts do not lose history.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pair_cnt_q <= '0;
    end else if (!flush_i && pop) begin
      pair_cnt_q <= pair_cnt_q + 32'd1;
    end
  end

  assign pair_cnt_o = pair_cnt_q;
`endif

  assign we_a_o     = we_q;
  assign we_b_o     = we_q;
  assign addr_a_o   = out_a_q[EW-1:DATA_WIDTH];
  assign addr_b_o   = out_b_q[EW-1:DATA_WIDTH];
  assign data_a_o   = out_a_q[DATA_WIDTH-1:0];
  assign data_b_o   = out_b_q[DATA_WIDTH-1:0];
  assign full_a_o   = full_a;
  assign full_b_o   = full_b;
  assign skew_err_o = skew_err_q;
  assign ovf_err_o  = ovf_err_q;

endmodule

// File: tb/tb_wb_align.sv
// Directed bench for wb_align (default parameters: DEPTH=4, SKEW_MAX=8).
module tb_wb_align;
  logic        clk = 1'b0;
  logic        rst, flush;
  logic        we_a, we_b;
  logic [4:0]  addr_a, addr_b;
  logic [31:0] data_a, data_b;
  logic        we_a_o, we_b_o, full_a_o, full_b_o, skew_err_o, ovf_err_o;
  logic [4:0]  addr_a_o, addr_b_o;
  logic [31:0] data_a_o, data_b_o;
`ifdef WB_ALIGN_STATS_EN
  logic [31:0] pair_cnt_o;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wb_align dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .we_a_i(we_a), .addr_a_i(addr_a), .data_a_i(data_a),
    .we_b_i(we_b), .addr_b_i(addr_b), .data_b_i(data_b),
    .we_a_o(we_a_o), .we_b_o(we_b_o),
    .addr_a_o(addr_a_o), .addr_b_o(addr_b_o),
    .data_a_o(data_a_o), .data_b_o(data_b_o),
    .full_a_o(full_a_o), .full_b_o(full_b_o),
    .skew_err_o(skew_err_o), .ovf_err_o(ovf_err_o)
`ifdef WB_ALIGN_STATS_EN
    , .pair_cnt_o(pair_cnt_o)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wa, input logic [4:0] aa, input logic [31:0] da,
                       input logic wb, input logic [4:0] ab, input logic [31:0] db);
    we_a = wa; addr_a = aa; data_a = da;
    we_b = wb; addr_b = ab; data_b = db;
    step();
    we_a = 1'b0;
    we_b = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    we_a = 1'b0; we_b = 1'b0;
    addr_a = '0; addr_b = '0; data_a = '0; data_b = '0;
    step();
    step();
    rst = 1'b0;
    chk("rst_we_a", 32'(we_a_o), 32'd0);
    chk("rst_we_b", 32'(we_b_o), 32'd0);
    chk("rst_addr_a", 32'(addr_a_o), 32'd0);
    chk("rst_data_b", data_b_o, 32'd0);
    chk("rst_full_a", 32'(full_a_o), 32'd0);
    chk("rst_skew", 32'(skew_err_o), 32'd0);
    chk("rst_ovf", 32'(ovf_err_o), 32'd0);

    // Aligned single write: appears one edge later, lasts one cycle.
    drive(1'b1, 5'd3, 32'hDEADBEEF, 1'b1, 5'd3, 32'hDEADBEEF);
    chk("t1_no_bypass", 32'(we_a_o), 32'd0);
    step();
    chk("t1_we_a", 32'(we_a_o), 32'd1);
    chk("t1_we_b", 32'(we_b_o), 32'd1);
    chk("t1_addr_a", 32'(addr_a_o), 32'd3);
    chk("t1_addr_b", 32'(addr_b_o), 32'd3);
    chk("t1_data_a", data_a_o, 32'hDEADBEEF);
    chk("t1_data_b", data_b_o, 32'hDEADBEEF);
    step();
    chk("t1_one_cycle", 32'(we_a_o), 32'd0);
    chk("t1_addr_hold", 32'(addr_a_o), 32'd3);

    // Skew of three cycles: pairs come out in order 1,2,3.
    for (int i = 1; i <= 3; i++) drive(1'b1, 5'(i), 32'h100 + 32'(i), 1'b0, 5'd0, 32'd0);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd1, 32'h101);
    chk("t2_wait_b", 32'(we_a_o), 32'd0);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 32'h102);
    chk("t2_p1_we", 32'(we_b_o), 32'd1);
    chk("t2_p1_addr_a", 32'(addr_a_o), 32'd1);
    chk("t2_p1_addr_b", 32'(addr_b_o), 32'd1);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h103);
    chk("t2_p2_addr_a", 32'(addr_a_o), 32'd2);
    chk("t2_p2_data_b", data_b_o, 32'h102);
    step();
    chk("t2_p3_addr_a", 32'(addr_a_o), 32'd3);
    chk("t2_p3_data_a", data_a_o, 32'h103);
    step();
    chk("t2_done", 32'(we_a_o), 32'd0);
    chk("t2_skew", 32'(skew_err_o), 32'd0);

    // Timeout: one-sided A write, B silent.
    drive(1'b1, 5'd10, 32'hCAFE, 1'b0, 5'd0, 32'd0);
    for (int i = 1; i <= 7; i++) begin
      step();
      chk("t3_no_pulse", 32'(we_a_o), 32'd0);
    end
    chk("t3_skew_7", 32'(skew_err_o), 32'd0);
    step();
    chk("t3_skew_8", 32'(skew_err_o), 32'd1);
    drive(1'b1, 5'd6, 32'h66, 1'b1, 5'd6, 32'h66);
    step();
    chk("t3_err_no_pop", 32'(we_a_o), 32'd0);
    chk("t3_err_no_ovf", 32'(ovf_err_o), 32'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t3_flush_skew", 32'(skew_err_o), 32'd0);
    chk("t3_flush_full", 32'(full_a_o), 32'd0);
    drive(1'b1, 5'd7, 32'h77, 1'b1, 5'd7, 32'h77);
    step();
    chk("t3_post_we", 32'(we_a_o), 32'd1);
    chk("t3_post_addr_a", 32'(addr_a_o), 32'd7);
    chk("t3_post_data_a", data_a_o, 32'h77);
    step();

    // Overflow: five A pushes into a four-entry FIFO, then four B pushes.
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 5'(i), 32'hA0 + 32'(i), 1'b0, 5'd0, 32'd0);
      if (i == 3) chk("t4_not_full", 32'(full_a_o), 32'd0);
      if (i == 4) begin
        chk("t4_full", 32'(full_a_o), 32'd1);
        chk("t4_no_ovf_yet", 32'(ovf_err_o), 32'd0);
      end
      if (i == 5) begin
        chk("t4_ovf", 32'(ovf_err_o), 32'd1);
        chk("t4_still_full", 32'(full_a_o), 32'd1);
      end
    end
    for (int i = 1; i <= 4; i++) begin
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'(i), 32'hB0 + 32'(i));
      if (i == 1) begin
        chk("t4_first_wait", 32'(we_a_o), 32'd0);
      end else begin
        chk("t4_pair_we", 32'(we_a_o), 32'd1);
        chk("t4_pair_data_a", data_a_o, 32'hA0 + 32'(i - 1));
        chk("t4_pair_data_b", data_b_o, 32'hB0 + 32'(i - 1));
      end
    end
    step();
    chk("t4_last_data_a", data_a_o, 32'hA4);
    chk("t4_last_data_b", data_b_o, 32'hB4);
    step();
    chk("t4_only_four", 32'(we_a_o), 32'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t4_flush_ovf", 32'(ovf_err_o), 32'd0);

    // Reset with writes queued and a pop due at the reset edge.
    drive(1'b1, 5'd9, 32'h91, 1'b0, 5'd0, 32'd0);
    drive(1'b1, 5'd9, 32'h92, 1'b0, 5'd0, 32'd0);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h91);
    rst = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h92);
    rst = 1'b0;
    chk("t5_we_a", 32'(we_a_o), 32'd0);
    chk("t5_we_b", 32'(we_b_o), 32'd0);
    chk("t5_addr_a", 32'(addr_a_o), 32'd0);
    chk("t5_addr_b", 32'(addr_b_o), 32'd0);
    chk("t5_data_a", data_a_o, 32'd0);
    chk("t5_data_b", data_b_o, 32'd0);
    chk("t5_full_a", 32'(full_a_o), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_no_stale", 32'(we_a_o), 32'd0);
    end

`ifdef WB_ALIGN_STATS_EN
    chk("t6_cnt_rst", pair_cnt_o, 32'd0);
    for (int i = 0; i < 10; i++) drive(1'b1, 5'(i), 32'(i), 1'b1, 5'(i), 32'(i));
    step();
    chk("t6_cnt_10", pair_cnt_o, 32'd10);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t6_cnt_flush", pair_cnt_o, 32'd10);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_cnt_reset", pair_cnt_o, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
